// File: rtl/reg_file.sv
// rtl/reg_file.sv - 31x32 register file with write-through bypass and per-register pending-write scoreboard
module reg_file (
    input  logic        clk,
    input  logic        nrst,
    input  logic [4:0]  i_ID_reg_RegAddr1,
    input  logic [4:0]  i_ID_reg_RegAddr2,
    input  logic        i_ID_reg_Use1,
    input  logic        i_ID_reg_Use2,
    output logic [31:0] o_ID_reg_RegData1,
    output logic [31:0] o_ID_reg_RegData2,
    input  logic        i_ID_reg_Issue,
    input  logic [4:0]  i_ID_reg_DstAddr,
    input  logic        i_WB_reg_RegWrite,
    input  logic [4:0]  i_WB_reg_RegAddr,
    input  logic [31:0] i_WB_reg_RegData,
    input  logic        i_ID_reg_Flush,
    output logic        o_ID_reg_Stall,
    output logic        o_ID_reg_Overflow,
    output logic        o_ID_reg_Underflow
);

    logic [31:0] regs [1:31];
    logic [1:0]  pend [1:31];
    logic        overflow;
    logic        underflow;
    logic        wb_en;
    logic        issue_en;
    logic        stall;

    assign wb_en = i_WB_reg_RegWrite && (i_WB_reg_RegAddr != 5'd0);

    function automatic logic [31:0] read_port(input logic [4:0] addr);
        if (addr == 5'd0)
            return 32'd0;
        else if (wb_en && (i_WB_reg_RegAddr == addr))
            return i_WB_reg_RegData;
        else
            return regs[addr];
    endfunction

    // A writeback landing this cycle retires one pending write; a count of 0 never goes negative.
    function automatic logic still_pending(input logic [4:0] addr);
        logic wb_hit;
        wb_hit = wb_en && (i_WB_reg_RegAddr == addr);
        if (addr == 5'd0)
            return 1'b0;
        else if (pend[addr] > 2'd1)
            return 1'b1;
        else
            return (pend[addr] == 2'd1) && !wb_hit;
    endfunction

    assign o_ID_reg_RegData1 = read_port(i_ID_reg_RegAddr1);
    assign o_ID_reg_RegData2 = read_port(i_ID_reg_RegAddr2);

    assign stall = (i_ID_reg_Use1 && still_pending(i_ID_reg_RegAddr1)) ||
                   (i_ID_reg_Use2 && still_pending(i_ID_reg_RegAddr2));
    assign o_ID_reg_Stall     = stall;
    assign o_ID_reg_Overflow  = overflow;
    assign o_ID_reg_Underflow = underflow;

    assign issue_en = i_ID_reg_Issue && (i_ID_reg_DstAddr != 5'd0) && !stall;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int a = 1; a < 32; a++) begin
                regs[a] <= 32'd0;
                pend[a] <= 2'd0;
            end
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wb_en)
                regs[i_WB_reg_RegAddr] <= i_WB_reg_RegData;
            if (i_ID_reg_Flush) begin
                for (int a = 1; a < 32; a++)
                    pend[a] <= 2'd0;
            end else begin
                for (int a = 1; a < 32; a++) begin
                    logic inc;
                    logic dec;
                    inc = issue_en && (i_ID_reg_DstAddr == 5'(a));
                    dec = wb_en && (i_WB_reg_RegAddr == 5'(a));
                    if (inc && !dec) begin
                        if (pend[a] == 2'd3)
                            overflow <= 1'b1;
                        else
                            pend[a] <= pend[a] + 2'd1;
                    end else if (dec && !inc) begin
                        if (pend[a] == 2'd0)
                            underflow <= 1'b1;
                        else
                            pend[a] <= pend[a] - 2'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - scoreboard bench for reg_file: directed vectors, queued expectations checked at negedge
module tb_reg_file;

    logic        clk;
    logic        nrst;
    logic [4:0]  addr1, addr2, dst, wb_addr;
    logic        use1, use2, issue, wb_we, flush;
    logic [31:0] wb_data;
    logic [31:0] rd1, rd2;
    logic        stall, ovf, udf;

    localparam int S_RD1 = 0, S_RD2 = 1, S_STALL = 2, S_OVF = 3, S_UDF = 4;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    reg_file dut (
        .clk                (clk),
        .nrst               (nrst),
        .i_ID_reg_RegAddr1  (addr1),
        .i_ID_reg_RegAddr2  (addr2),
        .i_ID_reg_Use1      (use1),
        .i_ID_reg_Use2      (use2),
        .o_ID_reg_RegData1  (rd1),
        .o_ID_reg_RegData2  (rd2),
        .i_ID_reg_Issue     (issue),
        .i_ID_reg_DstAddr   (dst),
        .i_WB_reg_RegWrite  (wb_we),
        .i_WB_reg_RegAddr   (wb_addr),
        .i_WB_reg_RegData   (wb_data),
        .i_ID_reg_Flush     (flush),
        .o_ID_reg_Stall     (stall),
        .o_ID_reg_Overflow  (ovf),
        .o_ID_reg_Underflow (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_RD1:   return rd1;
            S_RD2:   return rd2;
            S_STALL: return {31'd0, stall};
            S_OVF:   return {31'd0, ovf};
            default: return {31'd0, udf};
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = q.pop_front();
            act = observe(e.sel);
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_val(input int sel, input logic [31:0] v, input string name);
        exp_t e;
        e.sel = sel;
        e.exp = v;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        nrst = 1'b1;
        addr1 = 5'd0; addr2 = 5'd0; use1 = 1'b0; use2 = 1'b0;
        issue = 1'b0; dst = 5'd0; wb_we = 1'b0; wb_addr = 5'd0;
        wb_data = 32'd0; flush = 1'b0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_we = 1'b1; wb_addr = a; wb_data = d;
    endtask

    initial begin
        nrst = 1'b0;
        addr1 = 5'd0; addr2 = 5'd0; use1 = 1'b0; use2 = 1'b0;
        issue = 1'b0; dst = 5'd0; wb_we = 1'b0; wb_addr = 5'd0;
        wb_data = 32'd0; flush = 1'b0;

        // reset state
        next_cycle();
        addr1 = 5'd5;
        expect_val(S_RD1, 32'd0, "reset_rd1");
        expect_val(S_RD2, 32'd0, "reset_rd2_r0");
        expect_val(S_STALL, 32'd0, "reset_stall");
        expect_val(S_OVF, 32'd0, "reset_ovf");
        expect_val(S_UDF, 32'd0, "reset_udf");

        // write r5, read back; r0 writes discarded
        next_cycle();
        wb(5'd5, 32'hDEADBEEF);
        next_cycle();
        addr1 = 5'd5;
        wb(5'd0, 32'h1234);
        expect_val(S_RD1, 32'hDEADBEEF, "r5_readback");
        expect_val(S_RD2, 32'd0, "r0_bypass_blocked");
        expect_val(S_UDF, 32'd1, "udf_wb_r5_count0");
        next_cycle();
        expect_val(S_RD2, 32'd0, "r0_stays_zero");

        // same-cycle bypass hides the old r7
        wb(5'd7, 32'h00000077);
        next_cycle();
        addr1 = 5'd7;
        wb(5'd7, 32'hA5A5A5A5);
        expect_val(S_RD1, 32'hA5A5A5A5, "bypass_r7");
        next_cycle();
        addr2 = 5'd7;
        expect_val(S_RD2, 32'hA5A5A5A5, "r7_stored");

        // reset clears flags and contents
        nrst = 1'b0;
        next_cycle();
        addr1 = 5'd7;
        expect_val(S_RD1, 32'd0, "r7_after_reset");
        expect_val(S_UDF, 32'd0, "udf_cleared");

        // issue r3, stall until its writeback
        issue = 1'b1; dst = 5'd3;
        next_cycle();
        addr1 = 5'd3; use1 = 1'b1;
        expect_val(S_STALL, 32'd1, "stall_r3_pending");
        next_cycle();
        addr1 = 5'd3; use1 = 1'b1; wb(5'd3, 32'h11);
        expect_val(S_STALL, 32'd0, "stall_released_by_wb");
        expect_val(S_RD1, 32'h11, "r3_bypass");
        next_cycle();
        addr1 = 5'd3; use1 = 1'b1;
        expect_val(S_STALL, 32'd0, "r3_count_zero");
        expect_val(S_RD1, 32'h11, "r3_stored");

        // simultaneous issue and writeback on r4 keeps count, then flush
        issue = 1'b1; dst = 5'd4;
        next_cycle();
        issue = 1'b1; dst = 5'd4; wb(5'd4, 32'h44);
        next_cycle();
        addr1 = 5'd4; use1 = 1'b1;
        expect_val(S_STALL, 32'd1, "r4_count_held_1");
        expect_val(S_RD1, 32'h44, "r4_stored");
        next_cycle();
        addr1 = 5'd4; use1 = 1'b1; flush = 1'b1;
        expect_val(S_STALL, 32'd1, "stall_during_flush");
        next_cycle();
        addr1 = 5'd4; use1 = 1'b1;
        expect_val(S_STALL, 32'd0, "stall_after_flush");
        expect_val(S_OVF, 32'd0, "ovf_clear_pre");
        expect_val(S_UDF, 32'd0, "udf_clear_pre");

        // saturate r9 and underflow r10
        for (int i = 0; i < 3; i++) begin
            issue = 1'b1; dst = 5'd9;
            next_cycle();
        end
        issue = 1'b1; dst = 5'd9;
        expect_val(S_OVF, 32'd0, "ovf_at_count3");
        next_cycle();
        addr1 = 5'd9; use1 = 1'b1;
        expect_val(S_OVF, 32'd1, "ovf_set");
        expect_val(S_STALL, 32'd1, "stall_r9");
        wb(5'd10, 32'h10);
        next_cycle();
        expect_val(S_UDF, 32'd1, "udf_set_r10");
        next_cycle();
        next_cycle();
        expect_val(S_OVF, 32'd1, "ovf_sticky");
        expect_val(S_UDF, 32'd1, "udf_sticky");

        // issue while stalled is dropped
        flush = 1'b1;
        next_cycle();
        issue = 1'b1; dst = 5'd2;
        next_cycle();
        issue = 1'b1; dst = 5'd2; addr2 = 5'd2; use2 = 1'b1;
        expect_val(S_STALL, 32'd1, "stall_r2");
        next_cycle();
        addr2 = 5'd2; use2 = 1'b1; wb(5'd2, 32'h22);
        expect_val(S_STALL, 32'd0, "stalled_issue_ignored");
        next_cycle();
        issue = 1'b1; dst = 5'd2;
        next_cycle();
        nrst = 1'b0; issue = 1'b1; dst = 5'd2; addr1 = 5'd2;
        wb(5'd4, 32'h55);
        expect_val(S_RD1, 32'h22, "rd_during_reset_cycle");
        next_cycle();
        addr1 = 5'd2; use1 = 1'b1; addr2 = 5'd4; use2 = 1'b1;
        expect_val(S_RD1, 32'd0, "r2_after_reset");
        expect_val(S_RD2, 32'd0, "r4_after_reset");
        expect_val(S_STALL, 32'd0, "stall_after_reset");
        expect_val(S_OVF, 32'd0, "ovf_after_reset");
        expect_val(S_UDF, 32'd0, "udf_after_reset");

        next_cycle();
        next_cycle();
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
